// File: rtl/plot_receiver.sv
// plot_receiver: clips (x,y,colour) plot strobes, queues on-screen pixels and
// issues each as a held linear-address framebuffer write.
module plot_receiver #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              plot,
  input  logic [9:0]        x_in,
  input  logic [8:0]        y_in,
  input  logic [2:0]        colour_in,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [3:0]        fifo_level,
  output logic [15:0]       drop_count,
  output logic              idle
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WRITE} state_t;
  state_t            r_state;
  logic [21:0]       r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [3:0]        r_level;
  logic [21:0]       r_pix;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_data;
  logic              r_we;
  logic [15:0]       r_drop;
  logic              w_nonempty, w_ready, w_onscreen, w_push, w_pop;
  assign w_nonempty = r_level != 4'd0;
  assign w_ready    = r_level != 4'(FIFO_DEPTH);
  assign w_onscreen = (32'(x_in) < SCREEN_W) && (32'(y_in) < SCREEN_H);
  assign w_push     = plot && w_ready && w_onscreen;
  // The head leaves the FIFO when the FSM can take it: from idle, or as a write completes
  assign w_pop      = w_nonempty && (r_state == S_IDLE || (r_state == S_WRITE && mem_ack));
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= 4'd0;
      r_drop  <= 16'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= {colour_in, y_in, x_in};
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_level <= r_level + 4'(w_push) - 4'(w_pop);
      if (plot && !w_push && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pix   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_pix   <= r_fifo[r_rptr];
          r_state <= S_ADDR;
        end
        S_ADDR: begin
          r_addr  <= ADDR_W'(r_pix[18:10]) * ADDR_W'(SCREEN_W) + ADDR_W'(r_pix[9:0]);
          r_data  <= r_pix[21:19];
          r_we    <= 1'b1;
          r_state <= S_WRITE;
        end
        S_WRITE: if (mem_ack) begin
          r_we    <= 1'b0;
          r_pix   <= w_pop ? r_fifo[r_rptr] : r_pix;
          r_state <= w_pop ? S_ADDR : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign ready      = w_ready;
  assign mem_addr   = r_addr;
  assign mem_data   = r_data;
  assign mem_we     = r_we;
  assign fifo_level = r_level;
  assign drop_count = r_drop;
  assign idle       = !w_nonempty && r_state == S_IDLE;
endmodule
